// File: rtl/conv_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_seq_engine
// Description : Sequential 2-D valid-mode convolution engine. One shared
//               multiplier performs one multiply-accumulate per clock; each
//               output element is written after its window completes.
//               Optional macro CONV_SATURATE_EN: clamp written outputs to
//               2^EW-1 instead of truncating to EW bits.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_seq_engine #(
   parameter int  MAX_DIM = 5,
   parameter int  K_MAX   = 3,
   parameter int  EW      = 8,
   localparam int DW      = $clog2(MAX_DIM + 1),
   localparam int KW      = $clog2(K_MAX + 1),
   localparam int AW      = 2 * EW + $clog2(K_MAX * K_MAX)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DW-1:0]                 in_m,
   input  logic [DW-1:0]                 in_n,
   input  logic [KW-1:0]                 k_m,
   input  logic [KW-1:0]                 k_n,
   input  logic [MAX_DIM*MAX_DIM*EW-1:0] matrix_in,
   input  logic [K_MAX*K_MAX*EW-1:0]     kernel,
   output logic                          busy,
   output logic                          done,
   output logic                          valid,
   output logic                          err,
   output logic [DW-1:0]                 out_m,
   output logic [DW-1:0]                 out_n,
   output logic [MAX_DIM*MAX_DIM*EW-1:0] matrix_out,
   output logic [15:0]                   cycle_count
);

   localparam int NE = MAX_DIM * MAX_DIM;
   localparam int NK = K_MAX * K_MAX;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int JW = (NK > 1) ? $clog2(NK) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [EW-1:0]    r_mat [NE];
   logic [EW-1:0]    r_ker [NK];
   logic [EW-1:0]    r_res [NE];
   logic [AW-1:0]    r_acc;
   logic [KW-1:0]    r_k_m;
   logic [KW-1:0]    r_k_n;
   logic [DW-1:0]    r_out_m;
   logic [DW-1:0]    r_out_n;
   logic [DW-1:0]    r_i;
   logic [DW-1:0]    r_j;
   logic [KW-1:0]    r_ki;
   logic [KW-1:0]    r_kj;
   logic [15:0]      r_cycles;
   logic             r_valid;
   logic             r_err;

   logic             w_illegal;
   logic             w_last_tap;
   logic             w_last_col_tap;
   logic             w_last_win;
   logic             w_last_col_win;
   logic [IW-1:0]    w_pix_idx;
   logic [IW-1:0]    w_out_idx;
   logic [JW-1:0]    w_tap_idx;
   logic [2*EW-1:0]  w_prod;
   logic [EW-1:0]    w_wr_val;

   // Request legality, evaluated on the live ports at the accepting edge
   always_comb begin
      w_illegal = (in_m == '0) || (in_n == '0) || (k_m == '0) || (k_n == '0) ||
                  (in_m > DW'(MAX_DIM)) || (in_n > DW'(MAX_DIM)) ||
                  (k_m > KW'(K_MAX)) || (k_n > KW'(K_MAX)) ||
                  (in_m < DW'(k_m)) || (in_n < DW'(k_n));
   end

   // Loop-end flags, element addressing and the shared multiplier
   always_comb begin
      w_last_col_tap = (r_kj == r_k_n - KW'(1));
      w_last_tap     = w_last_col_tap && (r_ki == r_k_m - KW'(1));
      w_last_col_win = (r_j == r_out_n - DW'(1));
      w_last_win     = w_last_col_win && (r_i == r_out_m - DW'(1));
      w_pix_idx = IW'((32'(r_i) + 32'(r_ki)) * 32'(MAX_DIM) + 32'(r_j) + 32'(r_kj));
      w_tap_idx = JW'(32'(r_ki) * 32'(K_MAX) + 32'(r_kj));
      w_out_idx = IW'(32'(r_i) * 32'(MAX_DIM) + 32'(r_j));
      w_prod    = (2*EW)'(r_mat[w_pix_idx]) * (2*EW)'(r_ker[w_tap_idx]);
`ifdef CONV_SATURATE_EN
      w_wr_val  = (r_acc[AW-1:EW] != '0) ? {EW{1'b1}} : r_acc[EW-1:0];
`else
      w_wr_val  = r_acc[EW-1:0];
`endif
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_illegal ? S_DONE : S_MAC;
         S_MAC:   if (w_last_tap) w_next = S_WRITE;
         S_WRITE: w_next = w_last_win ? S_DONE : S_MAC;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand latching, accumulation, result writeback and bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < NE; e++) begin
            r_mat[e] <= '0;
            r_res[e] <= '0;
         end
         for (int e = 0; e < NK; e++) r_ker[e] <= '0;
         r_acc    <= '0;
         r_k_m    <= '0;
         r_k_n    <= '0;
         r_out_m  <= '0;
         r_out_n  <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_ki     <= '0;
         r_kj     <= '0;
         r_cycles <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int e = 0; e < NE; e++) begin
                     r_mat[e] <= matrix_in[e*EW +: EW];
                     r_res[e] <= '0;
                  end
                  for (int e = 0; e < NK; e++) r_ker[e] <= kernel[e*EW +: EW];
                  r_acc    <= '0;
                  r_k_m    <= k_m;
                  r_k_n    <= k_n;
                  r_i      <= '0;
                  r_j      <= '0;
                  r_ki     <= '0;
                  r_kj     <= '0;
                  r_cycles <= '0;
                  r_valid  <= 1'b0;
                  r_err    <= w_illegal;
                  // Result dimensions are known up front; zero when rejected
                  r_out_m  <= w_illegal ? '0 : (in_m - DW'(k_m) + DW'(1));
                  r_out_n  <= w_illegal ? '0 : (in_n - DW'(k_n) + DW'(1));
               end
            end
            S_MAC: begin
               r_acc <= r_acc + AW'(w_prod);
               if (w_last_col_tap) begin
                  r_kj <= '0;
                  r_ki <= w_last_tap ? '0 : (r_ki + KW'(1));
               end else begin
                  r_kj <= r_kj + KW'(1);
               end
               if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
            end
            S_WRITE: begin
               r_res[w_out_idx] <= w_wr_val;
               r_acc <= '0;
               if (w_last_col_win) begin
                  r_j <= '0;
                  r_i <= r_i + DW'(1);
               end else begin
                  r_j <= r_j + DW'(1);
               end
               if (w_last_win) r_valid <= 1'b1;
               if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
            end
            default: ;
         endcase
      end
   end

   genvar g;
   generate
      for (g = 0; g < NE; g++) begin : g_pack
         assign matrix_out[g*EW +: EW] = r_res[g];
      end
   endgenerate

   assign busy        = (r_state == S_MAC) || (r_state == S_WRITE);
   assign done        = (r_state == S_DONE);
   assign valid       = r_valid;
   assign err         = r_err;
   assign out_m       = r_out_m;
   assign out_n       = r_out_n;
   assign cycle_count = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_seq_engine
// Description : Scoreboard bench for conv_seq_engine. Jobs push their expected
//               result (from a direct convolution model) into a queue; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_seq_engine;

   localparam int MAX_DIM = 5;
   localparam int K_MAX   = 3;
   localparam int EW      = 8;
   localparam int DW      = 3;
   localparam int KW      = 2;
   localparam int NE      = MAX_DIM * MAX_DIM;
   localparam int NK      = K_MAX * K_MAX;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DW-1:0]     in_m, in_n;
   logic [KW-1:0]     k_m, k_n;
   logic [NE*EW-1:0]  matrix_in;
   logic [NK*EW-1:0]  kernel;
   logic              busy, done, valid, err;
   logic [DW-1:0]     out_m, out_n;
   logic [NE*EW-1:0]  matrix_out;
   logic [15:0]       cycle_count;

   typedef struct {
      logic [NE*EW-1:0] mo;
      int               om;
      int               oc;
      bit               v;
      bit               e;
      int               cc;
   } exp_t;

   exp_t q[$];
   exp_t mon_x;
   int   a_mat [MAX_DIM][MAX_DIM];
   int   a_ker [K_MAX][K_MAX];
   int   n_checks = 0;
   int   n_errors = 0;

   conv_seq_engine #(.MAX_DIM(MAX_DIM), .K_MAX(K_MAX), .EW(EW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_m(in_m), .in_n(in_n), .k_m(k_m), .k_n(k_n),
      .matrix_in(matrix_in), .kernel(kernel),
      .busy(busy), .done(done), .valid(valid), .err(err),
      .out_m(out_m), .out_n(out_n), .matrix_out(matrix_out),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Direct valid-mode convolution over the operand arrays
   function automatic exp_t model(input int im, input int inn, input int km, input int kn);
      exp_t x;
      int   s;
      x.mo = '0; x.om = 0; x.oc = 0; x.v = 1'b0; x.e = 1'b0; x.cc = 0;
      if (im < 1 || inn < 1 || km < 1 || kn < 1 || im > MAX_DIM || inn > MAX_DIM ||
          km > K_MAX || kn > K_MAX || im < km || inn < kn) begin
         x.e = 1'b1;
         return x;
      end
      x.om = im - km + 1;
      x.oc = inn - kn + 1;
      x.v  = 1'b1;
      x.cc = x.om * x.oc * (km * kn + 1);
      for (int r = 0; r < x.om; r++)
         for (int c = 0; c < x.oc; c++) begin
            s = 0;
            for (int a = 0; a < km; a++)
               for (int b = 0; b < kn; b++)
                  s += a_mat[r+a][c+b] * a_ker[a][b];
`ifdef CONV_SATURATE_EN
            if (s > 255) s = 255;
`endif
            x.mo[(r*MAX_DIM+c)*EW +: EW] = 8'(s);
         end
      return x;
   endfunction

   task automatic drive_ops(input int im, input int inn, input int km, input int kn);
      in_m = DW'(im); in_n = DW'(inn); k_m = KW'(km); k_n = KW'(kn);
      for (int r = 0; r < MAX_DIM; r++)
         for (int c = 0; c < MAX_DIM; c++)
            matrix_in[(r*MAX_DIM+c)*EW +: EW] = 8'(a_mat[r][c]);
      for (int r = 0; r < K_MAX; r++)
         for (int c = 0; c < K_MAX; c++)
            kernel[(r*K_MAX+c)*EW +: EW] = 8'(a_ker[r][c]);
   endtask

   task automatic scramble_ports();
      for (int e = 0; e < NE; e++) matrix_in[e*EW +: EW] = 8'($urandom);
      for (int e = 0; e < NK; e++) kernel[e*EW +: EW] = 8'($urandom);
      in_m = DW'($urandom_range(0, 7)); in_n = DW'($urandom_range(0, 7));
      k_m  = KW'($urandom_range(0, 3)); k_n  = KW'($urandom_range(0, 3));
   endtask

   task automatic fill(input int mv, input int kv);
      for (int r = 0; r < MAX_DIM; r++)
         for (int c = 0; c < MAX_DIM; c++)
            a_mat[r][c] = (mv < 0) ? int'($urandom_range(0, 255)) : mv;
      for (int r = 0; r < K_MAX; r++)
         for (int c = 0; c < K_MAX; c++)
            a_ker[r][c] = (kv < 0) ? int'($urandom_range(0, 255)) : kv;
   endtask

   task automatic run_job(input int im, input int inn, input int km, input int kn,
                          input bit pulse_mid, input bit pulse_done);
      exp_t x;
      int   n;
      x = model(im, inn, km, kn);
      q.push_back(x);
      @(negedge clk);
      drive_ops(im, inn, km, kn);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_ports();
      n = 0;
      while (busy && n < 5000) begin
         start = (pulse_mid && n == 2);
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", 256'(n), 256'(x.cc));
      chk("done_pulse", 256'(done), 256'(1));
      if (pulse_done) begin
         drive_ops(3, 3, 1, 1);
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 256'(done), 256'(0));
      chk("idle_after_done", 256'(busy), 256'(0));
      chk("hold_valid", 256'(valid), 256'(x.v));
      chk("hold_matrix_out", 256'(matrix_out), 256'(x.mo));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 256'(busy), 256'(0));
      chk({tag, "_done"}, 256'(done), 256'(0));
      chk({tag, "_valid"}, 256'(valid), 256'(0));
      chk({tag, "_err"}, 256'(err), 256'(0));
      chk({tag, "_out_m"}, 256'(out_m), 256'(0));
      chk({tag, "_out_n"}, 256'(out_n), 256'(0));
      chk({tag, "_matrix_out"}, 256'(matrix_out), 256'(0));
      chk({tag, "_cycle_count"}, 256'(cycle_count), 256'(0));
   endtask

   // Scoreboard monitor: every done pulse must match the oldest pending job
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending job");
         end else begin
            mon_x = q.pop_front();
            chk("res_matrix_out", 256'(matrix_out), 256'(mon_x.mo));
            chk("res_out_m", 256'(out_m), 256'(mon_x.om));
            chk("res_out_n", 256'(out_n), 256'(mon_x.oc));
            chk("res_valid", 256'(valid), 256'(mon_x.v));
            chk("res_err", 256'(err), 256'(mon_x.e));
            chk("res_cycle_count", 256'(cycle_count), 256'(mon_x.cc));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int im, inn, km, kn;
      reset = 1'b0; start = 1'b0;
      in_m = '0; in_n = '0; k_m = '0; k_n = '0; matrix_in = '0; kernel = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      fill(1, 1);    run_job(3, 3, 3, 3, 1'b0, 1'b0);
      fill(16, 1);   run_job(5, 5, 3, 3, 1'b0, 1'b0);
      fill(255, 255); run_job(5, 5, 1, 1, 1'b0, 1'b1);
      fill(-1, -1);  run_job(3, 3, 0, 2, 1'b0, 1'b0);
      fill(-1, -1);  run_job(2, 3, 3, 3, 1'b0, 1'b1);
      fill(-1, -1);  run_job(5, 5, 3, 3, 1'b1, 1'b0);
      fill(-1, -1);  run_job(4, 5, 2, 3, 1'b1, 1'b1);

      // Abort a 5x5/3x3 job partway; nothing is queued for it
      fill(-1, -1);
      @(negedge clk);
      drive_ops(5, 5, 3, 3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero("abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      fill(-1, -1);  run_job(5, 5, 3, 3, 1'b0, 1'b0);

      for (int jb = 0; jb < 40; jb++) begin
         if ($urandom_range(0, 5) == 0) begin
            im = $urandom_range(0, 7); inn = $urandom_range(0, 7);
            km = $urandom_range(0, 3); kn = $urandom_range(0, 3);
         end else begin
            im  = $urandom_range(1, 5); inn = $urandom_range(1, 5);
            km  = $urandom_range(1, (im < 3) ? im : 3);
            kn  = $urandom_range(1, (inn < 3) ? inn : 3);
         end
         fill(-1, -1);
         run_job(im, inn, km, kn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 256'(q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
